// File: rtl/micro_sequencer.sv
// micro_sequencer
//
// Microcode sequencer for the control unit. It walks a 9-bit microcode
// address space ({opcode, step}) and decodes each 14-bit micro-instruction
// read from an asynchronous ROM into the control word that drives the ALU,
// memory, bus selectors and registers rax..rdx. It also handles opcode
// latching, end-of-instruction, halt and memory-wait stalls.
//
// Ports
//   clk                   in   system clock, all state on rising edge
//   rst                   in   asynchronous active-high reset
//   uword_i[13:0]         in   micro-instruction at uaddr_o (same cycle)
//   data_i[7:0]           in   data bus, opcode taken from data_i[5:0]
//   mem_ready_i           in   memory completes current READ/WRITE
//   uaddr_o[8:0]          out  current microcode address
//   alu_op_o[3:0]         out  ALU operation
//   alu_enable_o          out  high when alu_op_o is not ALU_NOP
//   memory_op_o[2:0]      out  NOP=0, READ=1, WRITE=2
//   data_word_selector_o  out  data word selector
//   bus_selector_o        out  0=MAR, 1=PC
//   rax_op_o..rdx_op_o    out  register op per register (2 bits each)
//   reset_o               out  high during the reset pulse state
//   halt_o                out  halt request / halted indication
//   control_unit_load_o   out  opcode is being loaded this cycle
//   next_instr_o          out  instruction ends this cycle

module micro_sequencer #(
    parameter int UADDR_WIDTH = 9,
    parameter int UWORD_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UWORD_WIDTH-1:0] uword_i,
    input  logic [7:0]             data_i,
    input  logic                   mem_ready_i,
    output logic [UADDR_WIDTH-1:0] uaddr_o,
    output logic [3:0]             alu_op_o,
    output logic                   alu_enable_o,
    output logic [2:0]             memory_op_o,
    output logic                   data_word_selector_o,
    output logic                   bus_selector_o,
    output logic [1:0]             rax_op_o,
    output logic [1:0]             rbx_op_o,
    output logic [1:0]             rcx_op_o,
    output logic [1:0]             rdx_op_o,
    output logic                   reset_o,
    output logic                   halt_o,
    output logic                   control_unit_load_o,
    output logic                   next_instr_o
);

    typedef enum logic [1:0] {
        ST_RST_PULSE,
        ST_FETCH,
        ST_EXEC,
        ST_HALTED
    } state_e;

    typedef enum logic [2:0] {
        MEM_NOP   = 3'd0,
        MEM_READ  = 3'd1,
        MEM_WRITE = 3'd2
    } memory_op_e;

    typedef enum logic [1:0] {
        REG_NOP    = 2'd0,
        REG_LOAD   = 2'd1,
        REG_ENABLE = 2'd2
    } reg_op_e;

    typedef enum logic [1:0] {
        SEQ_CONT    = 2'd0,
        SEQ_END     = 2'd1,
        SEQ_HALT    = 2'd2,
        SEQ_LOAD_OP = 2'd3
    } seq_e;

    state_e     state, state_nxt;
    logic [2:0] step, step_nxt;
    logic [5:0] opcode, opcode_nxt;

    // Decoded micro-word fields
    logic [3:0] f_alu;
    logic [1:0] f_mem_raw;
    logic [2:0] f_mem;
    logic [1:0] f_reg_raw;
    logic [1:0] f_reg;
    logic [1:0] f_idx;
    logic [1:0] f_seq;
    logic       stall;
    logic       unused_data_bits;

    assign f_alu     = uword_i[13:10];
    assign f_mem_raw = uword_i[9:8];
    assign f_reg_raw = uword_i[5:4];
    assign f_idx     = uword_i[3:2];
    assign f_seq     = uword_i[1:0];

    // The reserved encoding 3 of both mem_op and reg_op collapses to NOP
    assign f_mem = (f_mem_raw == 2'd3) ? MEM_NOP : {1'b0, f_mem_raw};
    assign f_reg = (f_reg_raw == 2'd3) ? REG_NOP : f_reg_raw;

    // A memory access that the memory has not completed freezes the sequencer
    assign stall = ((f_mem == MEM_READ) || (f_mem == MEM_WRITE)) && !mem_ready_i;

    // Only the low six bits of the data bus carry an opcode
    assign unused_data_bits = ^data_i[7:6];

    // State, step and opcode registers; reset aborts anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RST_PULSE;
            step   <= 3'd0;
            opcode <= 6'd0;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            opcode <= opcode_nxt;
        end
    end

    // Next-state logic and control word decode. In FETCH/EXEC the outputs
    // follow uword_i combinationally; seq actions only apply when not stalled,
    // so a stalled cycle simply repeats the same address and control word.
    always_comb begin
        state_nxt            = state;
        step_nxt             = step;
        opcode_nxt           = opcode;
        uaddr_o              = '0;
        alu_op_o             = 4'd0;
        alu_enable_o         = 1'b0;
        memory_op_o          = MEM_NOP;
        data_word_selector_o = 1'b0;
        bus_selector_o       = 1'b0;
        rax_op_o             = REG_NOP;
        rbx_op_o             = REG_NOP;
        rcx_op_o             = REG_NOP;
        rdx_op_o             = REG_NOP;
        reset_o              = 1'b0;
        halt_o               = 1'b0;
        control_unit_load_o  = 1'b0;
        next_instr_o         = 1'b0;

        case (state)
            ST_RST_PULSE: begin
                reset_o   = 1'b1;
                state_nxt = ST_FETCH;
                step_nxt  = 3'd0;
            end

            ST_HALTED: begin
                halt_o = 1'b1;
            end

            default: begin
                // The fetch routine lives in opcode slot 0
                if (state == ST_EXEC) begin
                    uaddr_o = {opcode, step};
                end else begin
                    uaddr_o = {6'd0, step};
                end

                alu_op_o             = f_alu;
                alu_enable_o         = (f_alu != 4'd0);
                memory_op_o          = f_mem;
                data_word_selector_o = uword_i[7];
                bus_selector_o       = uword_i[6];

                case (f_idx)
                    2'd0:    rax_op_o = f_reg;
                    2'd1:    rbx_op_o = f_reg;
                    2'd2:    rcx_op_o = f_reg;
                    default: rdx_op_o = f_reg;
                endcase

                if (!stall) begin
                    case (f_seq)
                        SEQ_CONT: begin
                            // Running off step 7 ends the instruction
                            if (step == 3'd7) begin
                                next_instr_o = 1'b1;
                                state_nxt    = ST_FETCH;
                                step_nxt     = 3'd0;
                            end else begin
                                step_nxt = step + 3'd1;
                            end
                        end
                        SEQ_END: begin
                            next_instr_o = 1'b1;
                            state_nxt    = ST_FETCH;
                            step_nxt     = 3'd0;
                        end
                        SEQ_HALT: begin
                            halt_o    = 1'b1;
                            state_nxt = ST_HALTED;
                            step_nxt  = 3'd0;
                        end
                        default: begin
                            // Opcode 0 is illegal and halts the machine
                            control_unit_load_o = 1'b1;
                            opcode_nxt          = data_i[5:0];
                            step_nxt            = 3'd0;
                            if (data_i[5:0] == 6'd0) begin
                                state_nxt = ST_HALTED;
                            end else begin
                                state_nxt = ST_EXEC;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//
// Directed bench for micro_sequencer. A small asynchronous ROM model feeds
// uword_i from uaddr_o. Each stimulus cycle pushes its hand-computed expected
// control word into a scoreboard queue; a monitor pops and compares on the
// falling clock edge (or immediately after a mid-cycle async reset).

module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] uword_i;
    logic [7:0]  data_i = 8'h00;
    logic        mem_ready_i = 1'b1;
    logic [8:0]  uaddr_o;
    logic [3:0]  alu_op_o;
    logic        alu_enable_o;
    logic [2:0]  memory_op_o;
    logic        data_word_selector_o;
    logic        bus_selector_o;
    logic [1:0]  rax_op_o;
    logic [1:0]  rbx_op_o;
    logic [1:0]  rcx_op_o;
    logic [1:0]  rdx_op_o;
    logic        reset_o;
    logic        halt_o;
    logic        control_unit_load_o;
    logic        next_instr_o;

    logic [13:0] rom [0:511];
    logic [30:0] obs;

    typedef struct {
        string       name;
        logic [30:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    event mid_ev;

    micro_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .uword_i              (uword_i),
        .data_i               (data_i),
        .mem_ready_i          (mem_ready_i),
        .uaddr_o              (uaddr_o),
        .alu_op_o             (alu_op_o),
        .alu_enable_o         (alu_enable_o),
        .memory_op_o          (memory_op_o),
        .data_word_selector_o (data_word_selector_o),
        .bus_selector_o       (bus_selector_o),
        .rax_op_o             (rax_op_o),
        .rbx_op_o             (rbx_op_o),
        .rcx_op_o             (rcx_op_o),
        .rdx_op_o             (rdx_op_o),
        .reset_o              (reset_o),
        .halt_o               (halt_o),
        .control_unit_load_o  (control_unit_load_o),
        .next_instr_o         (next_instr_o)
    );

    always #5 clk = ~clk;

    // Asynchronous microcode ROM
    assign uword_i = rom[uaddr_o];

    assign obs = {uaddr_o, alu_op_o, alu_enable_o, memory_op_o,
                  data_word_selector_o, bus_selector_o,
                  rax_op_o, rbx_op_o, rcx_op_o, rdx_op_o,
                  reset_o, halt_o, control_unit_load_o, next_instr_o};

    // Expected control word; regs = {rax, rbx, rcx, rdx},
    // flags = {reset, halt, control_unit_load, next_instr}
    function automatic logic [30:0] mk(input logic [8:0] ua, input logic [3:0] alu,
                                       input logic [2:0] mem, input logic dws,
                                       input logic bs, input logic [7:0] regs,
                                       input logic [3:0] flags);
        return {ua, alu, (alu != 4'd0), mem, dws, bs, regs, flags};
    endfunction

    // Pops one expectation and compares it with the live DUT outputs
    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        total++;
        if (obs !== e.exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", e.name, obs, e.exp);
        end
    endtask

    // Monitor: compare whenever the DUT presents a settled control word
    always @(negedge clk) checkOutput();
    always @(mid_ev) checkOutput();

    // Drives one cycle of inputs just after the rising edge and records
    // what the DUT should present during that cycle
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic rdy,
                                 input string nm, input logic [30:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        data_i      = d;
        mem_ready_i = rdy;
        e.name = nm;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    logic [30:0] rstv;
    logic [30:0] hltv;
    logic [30:0] fetch_ld;

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 14'h0000;
        rom[9'h000] = 14'h0143; // LOAD_OP, mem READ, bus PC
        rom[9'h028] = 14'h0414; // op5 s0: ALU 1, LOAD rbx, CONT
        rom[9'h029] = 14'h0001; // op5 s1: END
        rom[9'h031] = 14'h0300; // op6 s1: reserved mem op, CONT
        rom[9'h032] = 14'h3C30; // op6 s2: ALU F, reserved reg op, CONT
        rom[9'h037] = 14'h012C; // op6 s7: READ, ENABLE rdx, CONT (wraps)
        rom[9'h038] = 14'h0802; // op7 s0: ALU 2, HALT
        rom[9'h043] = 14'h0E00; // op8 s3: ALU 3, WRITE, CONT

        rstv     = mk(9'h000, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b1000);
        hltv     = mk(9'h000, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0100);
        fetch_ld = mk(9'h000, 4'h0, 3'd1, 1'b0, 1'b1, 8'h00, 4'b0010);

        $display("[TB] start");

        // Reset held, then released
        applyStimulus(1'b1, 8'h00, 1'b1, "reset0", rstv);
        applyStimulus(1'b1, 8'h00, 1'b1, "reset1", rstv);
        applyStimulus(1'b1, 8'h00, 1'b1, "reset2", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "release", rstv);

        // Fetch/dispatch opcode 5 and execute it
        applyStimulus(1'b0, 8'h05, 1'b1, "fetch_op5", fetch_ld);
        applyStimulus(1'b0, 8'h00, 1'b1, "op5_s0",
                      mk(9'h028, 4'h1, 3'd0, 1'b0, 1'b0, 8'h10, 4'b0000));
        applyStimulus(1'b0, 8'h00, 1'b1, "op5_end",
                      mk(9'h029, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0001));

        // Opcode 6: reserved encodings, stall at step 7, wrap to fetch
        applyStimulus(1'b0, 8'h06, 1'b1, "fetch_op6", fetch_ld);
        applyStimulus(1'b0, 8'h00, 1'b1, "op6_s0",
                      mk(9'h030, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000));
        applyStimulus(1'b0, 8'h00, 1'b0, "op6_s1_memrsv",
                      mk(9'h031, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000));
        applyStimulus(1'b0, 8'h00, 1'b1, "op6_s2_regrsv",
                      mk(9'h032, 4'hF, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000));
        for (int s = 3; s < 7; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, "op6_walk",
                          mk(9'h030 + 9'(s), 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, "op6_stall",
                          mk(9'h037, 4'h0, 3'd1, 1'b0, 1'b0, 8'h02, 4'b0000));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, "op6_wrap",
                      mk(9'h037, 4'h0, 3'd1, 1'b0, 1'b0, 8'h02, 4'b0001));

        // Opcode 7 halts; HALTED ignores the fetch word and the inputs
        applyStimulus(1'b0, 8'h07, 1'b1, "fetch_op7", fetch_ld);
        applyStimulus(1'b0, 8'h00, 1'b1, "op7_halt",
                      mk(9'h038, 4'h2, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0100));
        applyStimulus(1'b0, 8'h05, 1'b1, "halted0", hltv);
        applyStimulus(1'b0, 8'h05, 1'b0, "halted1", hltv);
        applyStimulus(1'b0, 8'h00, 1'b1, "halted2", hltv);

        // Reset recovers; illegal opcode 0x00 halts
        applyStimulus(1'b1, 8'h00, 1'b1, "halt_rst", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "halt_rel", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "fetch_ill00", fetch_ld);
        applyStimulus(1'b0, 8'h00, 1'b1, "ill00_halted0", hltv);
        applyStimulus(1'b0, 8'h00, 1'b1, "ill00_halted1", hltv);

        // Illegal opcode via 0x40 (low six bits zero)
        applyStimulus(1'b1, 8'h00, 1'b1, "ill_rst", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "ill_rel", rstv);
        applyStimulus(1'b0, 8'h40, 1'b1, "fetch_ill40", fetch_ld);
        applyStimulus(1'b0, 8'h00, 1'b1, "ill40_halted", hltv);

        // Opcode 8, async reset in the middle of step 3
        applyStimulus(1'b1, 8'h00, 1'b1, "op8_rst", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "op8_rel", rstv);
        applyStimulus(1'b0, 8'h08, 1'b1, "fetch_op8", fetch_ld);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, "op8_walk",
                          mk(9'h040 + 9'(s), 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, "op8_s3",
                      mk(9'h043, 4'h3, 3'd2, 1'b0, 1'b0, 8'h00, 4'b0000));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        begin
            exp_t e;
            e.name = "async_mid";
            e.exp  = rstv;
            sb_q.push_back(e);
        end
        -> mid_ev;

        applyStimulus(1'b1, 8'h00, 1'b1, "mid_held", rstv);
        applyStimulus(1'b0, 8'h00, 1'b1, "mid_rel", rstv);
        applyStimulus(1'b0, 8'h05, 1'b1, "mid_fetch", fetch_ld);

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
